// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port between the memory-access stage and the data memory.
// The stage is the master; the memory (or its bus adapter) is the slave.
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_sel,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_sel,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: load/store decode, byte/half/word lanes, LL/SC link bit,
// misalignment detection and the MEM/WB register, over a req/ack data-memory port.
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  aluop_MEM,
    input  logic [31:0] mem_address_MEM,
    input  logic [31:0] reg_operation2_value_MEM,
    input  logic        is_write_MEM,
    input  logic [4:0]  write_regAddress_MEM,
    input  logic [31:0] write_regValue_MEM,
    input  logic        ll_clear,
    mem_access_stage_if.master dmem,
    output logic        stall_req,
    output logic        wb_is_write,
    output logic [4:0]  wb_regAddress,
    output logic [31:0] wb_regValue,
    output logic        align_exc,
    output logic [31:0] bad_vaddr
);

    localparam logic [7:0] OpLb  = 8'hE0;
    localparam logic [7:0] OpLh  = 8'hE1;
    localparam logic [7:0] OpLw  = 8'hE3;
    localparam logic [7:0] OpLbu = 8'hE4;
    localparam logic [7:0] OpLhu = 8'hE5;
    localparam logic [7:0] OpSb  = 8'hE8;
    localparam logic [7:0] OpSh  = 8'hE9;
    localparam logic [7:0] OpSw  = 8'hEB;
    localparam logic [7:0] OpLl  = 8'hF0;
    localparam logic [7:0] OpSc  = 8'hF8;

    typedef enum logic [0:0] {StIdle, StWaitAck} state_e;

    state_e state_q;
    logic   llbit_q;

    logic is_load, is_store, is_byte, is_half, is_word, is_signed, is_ll, is_sc;
    logic misaligned, fault, sc_fail, access;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        is_ll     = 1'b0;
        is_sc     = 1'b0;
        case (aluop_MEM)
            OpLb:  begin is_load = 1'b1;  is_byte = 1'b1; is_signed = 1'b1; end
            OpLh:  begin is_load = 1'b1;  is_half = 1'b1; is_signed = 1'b1; end
            OpLw:  begin is_load = 1'b1;  is_word = 1'b1; end
            OpLbu: begin is_load = 1'b1;  is_byte = 1'b1; end
            OpLhu: begin is_load = 1'b1;  is_half = 1'b1; end
            OpSb:  begin is_store = 1'b1; is_byte = 1'b1; end
            OpSh:  begin is_store = 1'b1; is_half = 1'b1; end
            OpSw:  begin is_store = 1'b1; is_word = 1'b1; end
            OpLl:  begin is_load = 1'b1;  is_word = 1'b1; is_ll = 1'b1; end
            OpSc:  begin is_store = 1'b1; is_word = 1'b1; is_sc = 1'b1; end
            default: ;
        endcase
    end

    // A misaligned SC faults even when its link bit is already lost.
    assign misaligned = (is_half & mem_address_MEM[0]) | (is_word & (|mem_address_MEM[1:0]));
    assign fault      = (is_load | is_store) & misaligned;
    assign sc_fail    = is_sc & ~llbit_q & ~misaligned;
    assign access     = (is_load | is_store) & ~misaligned & ~sc_fail;

    // The EX/MEM op register is unreset, so the request must be masked during reset.
    assign dmem.mem_req  = access & ~reset;
    assign dmem.mem_we   = access & ~reset & is_store;
    assign stall_req     = access & ~reset & ~dmem.mem_ack;
    assign dmem.mem_addr = {mem_address_MEM[31:2], 2'b00};

    always_comb begin
        dmem.mem_sel   = 4'b1111;
        dmem.mem_wdata = reg_operation2_value_MEM;
        if (is_store && is_byte) begin
            dmem.mem_sel   = 4'b0001 << mem_address_MEM[1:0];
            dmem.mem_wdata = {4{reg_operation2_value_MEM[7:0]}};
        end else if (is_store && is_half) begin
            dmem.mem_sel   = mem_address_MEM[1] ? 4'b1100 : 4'b0011;
            dmem.mem_wdata = {2{reg_operation2_value_MEM[15:0]}};
        end
    end

    always_comb begin
        rdata_shift = dmem.mem_rdata >> {mem_address_MEM[1:0], 3'b000};
        byte_lane   = rdata_shift[7:0];
        half_lane   = mem_address_MEM[1] ? dmem.mem_rdata[31:16] : dmem.mem_rdata[15:0];
        load_data   = dmem.mem_rdata;
        if (is_byte) begin
            load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
        end else if (is_half) begin
            load_data = {{16{is_signed & half_lane[15]}}, half_lane};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            llbit_q       <= 1'b0;
            wb_is_write   <= 1'b0;
            wb_regAddress <= 5'd0;
            wb_regValue   <= 32'd0;
            align_exc     <= 1'b0;
            bad_vaddr     <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle:    if (access && !dmem.mem_ack) state_q <= StWaitAck;
                StWaitAck: if (!access || dmem.mem_ack) state_q <= StIdle;
            endcase

            align_exc <= 1'b0;
            if (fault) begin
                align_exc   <= 1'b1;
                bad_vaddr   <= mem_address_MEM;
                wb_is_write <= 1'b0;
            end else if (access) begin
                if (!dmem.mem_ack) begin
                    wb_is_write <= 1'b0;
                end else if (is_load) begin
                    wb_is_write   <= is_write_MEM;
                    wb_regAddress <= write_regAddress_MEM;
                    wb_regValue   <= load_data;
                end else if (is_sc) begin
                    wb_is_write   <= is_write_MEM;
                    wb_regAddress <= write_regAddress_MEM;
                    wb_regValue   <= 32'd1;
                end else begin
                    wb_is_write <= 1'b0;
                end
            end else if (sc_fail) begin
                wb_is_write   <= is_write_MEM;
                wb_regAddress <= write_regAddress_MEM;
                wb_regValue   <= 32'd0;
            end else begin
                wb_is_write   <= is_write_MEM;
                wb_regAddress <= write_regAddress_MEM;
                wb_regValue   <= write_regValue_MEM;
            end

            if (ll_clear) begin
                llbit_q <= 1'b0;
            end else if (access && dmem.mem_ack && is_ll) begin
                llbit_q <= 1'b1;
            end else if (access && dmem.mem_ack && is_sc) begin
                llbit_q <= 1'b0;
            end
        end
    end

endmodule
